// File: rtl/amradio_wd_pkg.sv
// Shared definitions for the watchdog link: heartbeat FSM states and the
// default kick/timeout constants used by both heartbeat_gen and watchdog_timer.
package amradio_wd_pkg;

  typedef enum logic [1:0] {
    HB_IDLE  = 2'd0,
    HB_RUN   = 2'd1,
    HB_HOLD  = 2'd2,
    HB_FAULT = 2'd3
  } hb_state_e;

  localparam int unsigned WD_KICK_PERIOD  = 1_000_000;
  localparam int unsigned WD_LIVE_TIMEOUT = 4_000_000;
  localparam int unsigned WD_CNT_W        = 32;

endpackage

// File: rtl/wd_term_counter.sv
// CNT_W-bit up-counter with synchronous clear (dominant over enable) and a
// terminal-count flag that is high while the count equals TERM.
module wd_term_counter #(
  parameter int unsigned          CNT_W = amradio_wd_pkg::WD_CNT_W,
  parameter logic [CNT_W-1:0]     TERM  = '1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TERM);

endmodule

// File: rtl/heartbeat_gen.sv
// Kicking end of the watchdog link: periodic one-cycle heartbeat while the
// supervised path proves liveness, immediate kick on a warning edge, FAULT latch.
module heartbeat_gen
  import amradio_wd_pkg::*;
#(
  parameter int unsigned KICK_PERIOD  = WD_KICK_PERIOD,
  parameter int unsigned LIVE_TIMEOUT = WD_LIVE_TIMEOUT,
  parameter int unsigned CNT_W        = WD_CNT_W
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        alive,
  input  logic        wd_warning,
  input  logic        wd_triggered,
  input  logic        clear_fault,
  output logic        heartbeat,
  output logic [1:0]  state,
  output logic        fault,
  output logic [15:0] kick_count
);

  if (CNT_W < 1 || CNT_W > 32) begin : g_chk_width
    $error("heartbeat_gen: CNT_W must be in 1..32");
  end
  if (KICK_PERIOD < 2) begin : g_chk_period
    $error("heartbeat_gen: KICK_PERIOD must be >= 2");
  end
  if (LIVE_TIMEOUT <= KICK_PERIOD) begin : g_chk_timeout
    $error("heartbeat_gen: LIVE_TIMEOUT must exceed KICK_PERIOD");
  end
  if (64'(LIVE_TIMEOUT) > (64'd1 << CNT_W)) begin : g_chk_fit
    $error("heartbeat_gen: LIVE_TIMEOUT-1 does not fit in CNT_W bits");
  end

  hb_state_e   state_q, state_d;
  logic        hb_q, hb_d;
  logic        fault_q;
  logic        warn_q;
  logic [15:0] kc_q, kc_d;

  logic in_run, active, warn_edge, timeout;
  logic period_tc, live_tc, period_clr, live_clr;

  wd_term_counter #(
    .CNT_W (CNT_W),
    .TERM  (CNT_W'(KICK_PERIOD - 1))
  ) u_period_cnt (
    .clk_i  (clk),
    .rst_ni (rstn),
    .clr_i  (period_clr),
    .en_i   (in_run),
    .tc_o   (period_tc)
  );

  wd_term_counter #(
    .CNT_W (CNT_W),
    .TERM  (CNT_W'(LIVE_TIMEOUT - 1))
  ) u_live_cnt (
    .clk_i  (clk),
    .rst_ni (rstn),
    .clr_i  (live_clr),
    .en_i   (in_run),
    .tc_o   (live_tc)
  );

  always_comb begin
    in_run    = (state_q == HB_RUN);
    active    = in_run & enable & ~wd_triggered;
    warn_edge = wd_warning & ~warn_q;
    timeout   = in_run & live_tc & ~alive;
    // A warning edge landing on the pulse cycle itself is absorbed so the
    // heartbeat never stretches to two cycles.
    hb_d       = active & ~timeout & (period_tc | (warn_edge & ~hb_q));
    period_clr = ~active | timeout | hb_d;
    live_clr   = ~active | timeout | alive;

    kc_d = kc_q;
    if (hb_d && kc_q != '1) begin
      kc_d = kc_q + 16'd1;
    end

    state_d = state_q;
    if (wd_triggered) begin
      state_d = HB_FAULT;
    end else if (state_q == HB_FAULT) begin
      if (clear_fault) state_d = HB_IDLE;
    end else if (!enable) begin
      state_d = HB_IDLE;
    end else begin
      unique case (state_q)
        HB_IDLE: state_d = HB_RUN;
        HB_RUN:  if (timeout) state_d = HB_HOLD;
        HB_HOLD: if (alive)   state_d = HB_RUN;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= HB_IDLE;
      hb_q    <= 1'b0;
      fault_q <= 1'b0;
      warn_q  <= 1'b0;
      kc_q    <= '0;
    end else begin
      state_q <= state_d;
      hb_q    <= hb_d;
      fault_q <= (state_d == HB_FAULT);
      warn_q  <= wd_warning;
      kc_q    <= kc_d;
    end
  end

  assign heartbeat  = hb_q;
  assign state      = state_q;
  assign fault      = fault_q;
  assign kick_count = kc_q;

endmodule

// File: tb/tb_heartbeat_gen.sv
// Scoreboard bench for heartbeat_gen: a timestamp-based reference model predicts
// every cycle's outputs; a negedge monitor pops and compares them.
module tb_heartbeat_gen;

  localparam int K = 8;
  localparam int L = 20;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        enable = 1'b0, alive = 1'b0, wd_warning = 1'b0;
  logic        wd_triggered = 1'b0, clear_fault = 1'b0;
  logic        heartbeat, fault;
  logic [1:0]  state;
  logic [15:0] kick_count;

  heartbeat_gen #(
    .KICK_PERIOD  (K),
    .LIVE_TIMEOUT (L),
    .CNT_W        (32)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .enable       (enable),
    .alive        (alive),
    .wd_warning   (wd_warning),
    .wd_triggered (wd_triggered),
    .clear_fault  (clear_fault),
    .heartbeat    (heartbeat),
    .state        (state),
    .fault        (fault),
    .kick_count   (kick_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [1:0]  st;
    logic        hb;
    logic        flt;
    logic [15:0] kc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: state as 0..3, plus the cycle numbers at which the
  // period and liveness intervals last restarted.
  int m_st = 0;
  bit m_hb = 1'b0;
  int m_kc = 0;
  bit m_wprev = 1'b0;
  int p_start = 0;
  int l_start = 0;
  int tick = 0;

  task automatic push_exp(input int c);
    exp_t e;
    e.c   = c;
    e.st  = 2'(m_st);
    e.hb  = m_hb;
    e.flt = (m_st == 3);
    e.kc  = 16'(m_kc);
    q.push_back(e);
  endtask

  task automatic step(input bit en, input bit al, input bit w, input bit trg, input bit cf);
    int ns;
    bit run, tmo, wedge, pexp, kick;
    enable = en; alive = al; wd_warning = w; wd_triggered = trg; clear_fault = cf;
    run   = (m_st == 1);
    tmo   = run && !al && (cyc - l_start == L - 1);
    wedge = w && !m_wprev;
    pexp  = run && (cyc - p_start == K - 1);
    kick  = run && en && !trg && !tmo && (pexp || (wedge && !m_hb));
    if (trg)            ns = 3;
    else if (m_st == 3) ns = cf ? 0 : 3;
    else if (!en)       ns = 0;
    else if (m_st == 0) ns = 1;
    else if (m_st == 1) ns = tmo ? 2 : 1;
    else                ns = al ? 1 : 2;
    if (ns == 1 && m_st != 1) begin
      p_start = cyc + 1;
      l_start = cyc + 1;
    end else if (ns == 1) begin
      if (kick) p_start = cyc + 1;
      if (al)   l_start = cyc + 1;
    end
    if (kick && m_kc < 65535) m_kc++;
    m_hb = kick;
    m_st = ns;
    m_wprev = w;
    tick++;
    push_exp(cyc + 1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    q.delete();
    rstn = 1'b0;
    m_st = 0; m_hb = 1'b0; m_kc = 0; m_wprev = 1'b0;
    #1;
    push_exp(cyc);
    repeat (n) begin
      @(posedge clk); #1;
      push_exp(cyc);
    end
    rstn = 1'b1;
  endtask

  task automatic seek_period(input int target, input bit w);
    int n = 0;
    while (!(m_st == 1 && cyc - p_start == target) && n < 60) begin
      step(1'b1, (tick % 5) == 0, w, 1'b0, 1'b0);
      n++;
    end
    total++;
    if (n >= 60) begin
      bad++;
      $display("FAIL seek_period: period position %0d never reached (state %0d)", target, m_st);
    end
  endtask

  bit hb_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].c <= cyc) begin
      e = q.pop_front();
      total++;
      if (e.c != cyc) begin
        bad++;
        $display("FAIL stale_entry: cycle %0d expectation seen at cycle %0d", e.c, cyc);
      end else if ({state, heartbeat, fault, kick_count} !== {e.st, e.hb, e.flt, e.kc}) begin
        bad++;
        $display("FAIL outputs cyc=%0d: got state=%0d hb=%b fault=%b kc=%0d, want state=%0d hb=%b fault=%b kc=%0d",
                 cyc, state, heartbeat, fault, kick_count, e.st, e.hb, e.flt, e.kc);
      end
    end
    total++;
    if (heartbeat === 1'b1 && hb_prev) begin
      bad++;
      $display("FAIL hb_width cyc=%0d: heartbeat high two cycles, want single-cycle", cyc);
    end
    hb_prev = (heartbeat === 1'b1);
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit w, trg;
    int dens, n;
    @(posedge clk); #1;
    do_reset(3);

    // Routine kicks with alive every 5 cycles
    for (int i = 0; i < 30; i++) step(1'b1, (tick % 5) == 0, 1'b0, 1'b0, 1'b0);

    // Liveness loss -> HOLD, then one alive -> RUN
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 20; i++) step(1'b1, (i % 5) == 0, 1'b0, 1'b0, 1'b0);

    // Warning edge mid-period
    seek_period(3, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b1, (tick % 5) == 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)  step(1'b1, (tick % 5) == 0, 1'b0, 1'b0, 1'b0);

    // Warning edge on the period terminal cycle
    seek_period(K - 1, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, (tick % 5) == 0, 1'b1, 1'b0, 1'b0);
    step(1'b1, (tick % 5) == 0, 1'b0, 1'b0, 1'b0);

    // FAULT entry, ignored clear, real clear, back to RUN
    for (int i = 0; i < 3; i++) step(1'b1, (tick % 5) == 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, (tick % 5) == 0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b0, (tick % 5) == 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, (tick % 5) == 0, 1'b0, 1'b0, 1'b0);

    // Reset while the heartbeat pulse is high
    n = 0;
    while (!m_hb && n < 40) begin
      step(1'b1, (tick % 5) == 0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    total++;
    if (!m_hb) begin
      bad++;
      $display("FAIL seek_heartbeat: no heartbeat within 40 cycles, want one");
    end
    do_reset(2);

    // enable drop while running
    for (int i = 0; i < 6; i++) step(1'b1, (tick % 5) == 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic with varying liveness density
    w = 1'b0; trg = 1'b0;
    for (int blk = 0; blk < 15; blk++) begin
      dens = int'($urandom_range(2, 30));
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 7) == 0)  w = ~w;
        if ($urandom_range(0, 59) == 0) trg = ~trg;
        step($urandom_range(0, 24) != 0, $urandom_range(0, dens - 1) == 0,
             w, trg, $urandom_range(0, 3) == 0);
      end
      if (blk % 5 == 4) do_reset(1);
    end

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
